// File: rtl/wam_hit_validator_if.sv
// Whack-a-mole hit validator bus: game-side controls into the validator and
// scoring results back out. master = game controller, slave = validator.
interface wam_hit_validator_if #(
  parameter int N_BUTTONS = 5,
  parameter int SEL_W     = 3,
  parameter int SCORE_W   = 8
);
  logic [N_BUTTONS-1:0] buttons;
  logic [SEL_W-1:0]     selector;
  logic                 mole_valid;
  logic                 score_clr;
  logic                 hit_pulse;
  logic                 miss_pulse;
  logic [SCORE_W-1:0]   score;
  logic                 busy;

  modport master (
    output buttons, selector, mole_valid, score_clr,
    input  hit_pulse, miss_pulse, score, busy
  );

  modport slave (
    input  buttons, selector, mole_valid, score_clr,
    output hit_pulse, miss_pulse, score, busy
  );
endinterface

// File: rtl/wam_hit_validator.sv
// Whack-a-mole hit validator: synchronises raw buttons, classifies presses as
// hit/miss against the raised mole and keeps a saturating score.
// Optional: define MISS_PENALTY_EN to make each miss decrement the score.
module wam_hit_validator #(
  parameter int N_BUTTONS = 5,
  parameter int SEL_W     = 3,
  parameter int SCORE_W   = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  wam_hit_validator_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_LOCKOUT = 2'd2
  } state_t;

  state_t               state, state_next;
  logic [N_BUTTONS-1:0] sync1, sync2, prev, press;
  logic [N_BUTTONS-1:0] sel_mask;
  logic                 sel_in_range;
  logic                 hit_q, miss_q, busy_q;
  logic                 hit_next, miss_next;
  logic [SCORE_W-1:0]   score_q, score_next;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its source; blocking here would collapse the chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
      prev  <= '0;
    end else begin
      sync1 <= bus.buttons;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  assign press        = sync2 & ~prev;
  assign sel_in_range = (int'(bus.selector) < N_BUTTONS);
  assign sel_mask     = N_BUTTONS'(1) << bus.selector;

  // NOTE: every signal written here gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    hit_next   = 1'b0;
    miss_next  = 1'b0;

    unique case (state)
      ST_IDLE: begin
        if (bus.mole_valid) state_next = ST_ARMED;
      end
      ST_ARMED: begin
        if (|press) begin
          state_next = ST_LOCKOUT;
          // Only a lone press on an existing selected button counts as a hit.
          if (sel_in_range && (press == sel_mask)) hit_next  = 1'b1;
          else                                     miss_next = 1'b1;
        end else if (!bus.mole_valid) begin
          state_next = ST_IDLE;
        end
      end
      ST_LOCKOUT: begin
        if (!(|sync2) && !bus.mole_valid) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase

    score_next = score_q;
    if (bus.score_clr) begin
      score_next = '0;
    end else if (hit_next) begin
      if (score_q != '1) score_next = score_q + SCORE_W'(1);
`ifdef MISS_PENALTY_EN
    end else if (miss_next) begin
      if (score_q != '0) score_next = score_q - SCORE_W'(1);
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      hit_q   <= 1'b0;
      miss_q  <= 1'b0;
      busy_q  <= 1'b0;
      score_q <= '0;
    end else begin
      state   <= state_next;
      hit_q   <= hit_next;
      miss_q  <= miss_next;
      busy_q  <= (state_next == ST_LOCKOUT);
      score_q <= score_next;
    end
  end

  assign bus.hit_pulse  = hit_q;
  assign bus.miss_pulse = miss_q;
  assign bus.busy       = busy_q;
  assign bus.score      = score_q;

endmodule

// File: tb/tb_wam_hit_validator.sv
// Self-checking bench for wam_hit_validator: directed scenarios with constant
// expectations plus a randomized run scored against a behavioural game model.
module tb_wam_hit_validator;

  localparam int NB        = 5;
  localparam int SW        = 3;
  localparam int CW        = 3;
  localparam int SCORE_MAX = (1 << CW) - 1;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  wam_hit_validator_if #(.N_BUTTONS(NB), .SEL_W(SW), .SCORE_W(CW)) bus ();

  wam_hit_validator #(.N_BUTTONS(NB), .SEL_W(SW), .SCORE_W(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;

  // Behavioural model: a press is a rising level first visible two edges
  // after it was sampled; the game mode follows the mole/lockout rules.
  typedef enum {M_IDLE, M_ARMED, M_LOCKOUT} mode_t;
  mode_t          m_mode;
  logic [NB-1:0]  h1, h2, h3;
  int             m_score;
  bit             m_hit, m_miss;

  task automatic model_reset();
    m_mode  = M_IDLE;
    h1 = '0; h2 = '0; h3 = '0;
    m_score = 0;
    m_hit   = 1'b0;
    m_miss  = 1'b0;
  endtask

  task automatic model_edge(input logic [NB-1:0] b, input logic [SW-1:0] sel,
                            input logic mv, input logic clr);
    logic [NB-1:0] pressed, shifted;
    pressed = h2 & ~h3;
    shifted = pressed >> sel;
    m_hit   = 1'b0;
    m_miss  = 1'b0;
    case (m_mode)
      M_IDLE:  if (mv) m_mode = M_ARMED;
      M_ARMED: begin
        if (pressed != '0) begin
          if (int'(sel) < NB && $countones(pressed) == 1 && shifted[0]) m_hit = 1'b1;
          else m_miss = 1'b1;
          m_mode = M_LOCKOUT;
        end else if (!mv) begin
          m_mode = M_IDLE;
        end
      end
      default: if (h2 == '0 && !mv) m_mode = M_IDLE;
    endcase
    if (clr) m_score = 0;
    else if (m_hit) m_score = (m_score < SCORE_MAX) ? m_score + 1 : SCORE_MAX;
`ifdef MISS_PENALTY_EN
    else if (m_miss) m_score = (m_score > 0) ? m_score - 1 : 0;
`endif
    h3 = h2; h2 = h1; h1 = b;
  endtask

  // Apply inputs at a falling edge, let one rising edge happen, return at the
  // next falling edge where outputs are stable.
  task automatic drive(input logic [NB-1:0] b, input logic [SW-1:0] sel,
                       input logic mv, input logic clr);
    bus.buttons    = b;
    bus.selector   = sel;
    bus.mole_valid = mv;
    bus.score_clr  = clr;
    @(posedge clk);
    model_edge(b, sel, mv, clr);
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    bus.buttons = '0; bus.selector = '0; bus.mole_valid = 1'b0; bus.score_clr = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic hit_once(input logic [SW-1:0] sel, input logic clr_at_hit, output bit got_hit);
    logic [NB-1:0] m;
    m = NB'(1) << sel;
    drive('0, sel, 1'b1, 1'b0);
    drive(m, sel, 1'b1, 1'b0);
    drive(m, sel, 1'b1, 1'b0);
    drive(m, sel, 1'b1, clr_at_hit);
    got_hit = bus.hit_pulse;
    repeat (3) drive('0, sel, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    bus.buttons = '1; bus.selector = '0; bus.mole_valid = 1'b1; bus.score_clr = 1'b0;
    rst_n = 1'b0;
    @(posedge clk); #1;
    checks++; if (bus.hit_pulse !== 1'b0)  begin errors++; $display("FAIL reset_hit: got %b want 0", bus.hit_pulse); end
    checks++; if (bus.miss_pulse !== 1'b0) begin errors++; $display("FAIL reset_miss: got %b want 0", bus.miss_pulse); end
    checks++; if (bus.busy !== 1'b0)       begin errors++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    checks++; if (bus.score !== '0)        begin errors++; $display("FAIL reset_score: got %0d want 0", bus.score); end
  endtask

  task automatic test_hit_latency();
    do_reset();
    drive('0, 3'd2, 1'b1, 1'b0);
    drive(5'b00100, 3'd2, 1'b1, 1'b0);
    checks++; if (bus.hit_pulse !== 1'b0) begin errors++; $display("FAIL lat_edge1: got %b want 0", bus.hit_pulse); end
    drive(5'b00100, 3'd2, 1'b1, 1'b0);
    checks++; if (bus.hit_pulse !== 1'b0) begin errors++; $display("FAIL lat_edge2: got %b want 0", bus.hit_pulse); end
    drive(5'b00100, 3'd2, 1'b1, 1'b0);
    checks++; if (bus.hit_pulse !== 1'b1) begin errors++; $display("FAIL lat_edge3: got %b want 1", bus.hit_pulse); end
    checks++; if (bus.score !== 3'd1)     begin errors++; $display("FAIL hit_score: got %0d want 1", bus.score); end
    checks++; if (bus.busy !== 1'b1)      begin errors++; $display("FAIL hit_busy: got %b want 1", bus.busy); end
    drive(5'b00100, 3'd2, 1'b1, 1'b0);
    checks++; if (bus.hit_pulse !== 1'b0) begin errors++; $display("FAIL hit_width: got %b want 0", bus.hit_pulse); end
  endtask

  task automatic test_miss();
    do_reset();
    drive('0, 3'd1, 1'b1, 1'b0);
    repeat (3) drive(5'b01010, 3'd1, 1'b1, 1'b0);
    checks++; if (bus.miss_pulse !== 1'b1) begin errors++; $display("FAIL miss_pulse: got %b want 1", bus.miss_pulse); end
    checks++; if (bus.hit_pulse !== 1'b0)  begin errors++; $display("FAIL miss_nohit: got %b want 0", bus.hit_pulse); end
    checks++; if (bus.score !== 3'd0)      begin errors++; $display("FAIL miss_score: got %0d want 0", bus.score); end
  endtask

  task automatic test_lockout();
    logic [NB-1:0] pat [4] = '{5'b10100, 5'b00100, 5'b10100, 5'b00100};
    do_reset();
    drive('0, 3'd2, 1'b1, 1'b0);
    repeat (3) drive(5'b00100, 3'd2, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      drive(pat[i], 3'd2, 1'b1, 1'b0);
      checks++;
      if (bus.hit_pulse !== 1'b0 || bus.miss_pulse !== 1'b0) begin
        errors++; $display("FAIL lockout_quiet[%0d]: got hit=%b miss=%b want 0/0", i, bus.hit_pulse, bus.miss_pulse);
      end
    end
    drive('0, 3'd2, 1'b0, 1'b0);
    drive('0, 3'd2, 1'b0, 1'b0);
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL lockout_hold: got %b want 1", bus.busy); end
    drive('0, 3'd2, 1'b0, 1'b0);
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL lockout_exit: got %b want 0", bus.busy); end
  endtask

  task automatic test_saturation();
    bit got;
    int hits;
    do_reset();
    hits = 0;
    for (int i = 0; i < 8; i++) begin
      hit_once(3'd2, 1'b0, got);
      if (got) hits++;
      checks++;
      if (int'(bus.score) != ((i + 1 < SCORE_MAX) ? i + 1 : SCORE_MAX)) begin
        errors++; $display("FAIL sat_score[%0d]: got %0d want %0d", i, bus.score, (i + 1 < SCORE_MAX) ? i + 1 : SCORE_MAX);
      end
    end
    checks++; if (hits != 8) begin errors++; $display("FAIL sat_pulses: got %0d want 8", hits); end
    hit_once(3'd2, 1'b1, got);
    checks++; if (got !== 1'b1)      begin errors++; $display("FAIL clr_hit_pulse: got %b want 1", got); end
    checks++; if (bus.score !== '0)  begin errors++; $display("FAIL clr_priority: got %0d want 0", bus.score); end
  endtask

  task automatic test_bad_selector();
    bit got;
    int want;
    do_reset();
    repeat (3) hit_once(3'd0, 1'b0, got);
`ifdef MISS_PENALTY_EN
    want = 2;
`else
    want = 3;
`endif
    drive('0, 3'd6, 1'b1, 1'b0);
    repeat (3) drive(5'b10000, 3'd6, 1'b1, 1'b0);
    checks++; if (bus.miss_pulse !== 1'b1) begin errors++; $display("FAIL badsel_miss: got %b want 1", bus.miss_pulse); end
    checks++; if (bus.hit_pulse !== 1'b0)  begin errors++; $display("FAIL badsel_nohit: got %b want 0", bus.hit_pulse); end
    checks++; if (int'(bus.score) != want) begin errors++; $display("FAIL badsel_score: got %0d want %0d", bus.score, want); end
  endtask

  task automatic test_reset_abort();
    bit got;
    do_reset();
    repeat (4) hit_once(3'd2, 1'b0, got);
    drive('0, 3'd2, 1'b1, 1'b0);
    repeat (3) drive(5'b00100, 3'd2, 1'b1, 1'b0);
    checks++;
    if (bus.hit_pulse !== 1'b1 || bus.busy !== 1'b1 || bus.score !== 3'd5) begin
      errors++; $display("FAIL abort_setup: got hit=%b busy=%b score=%0d want 1/1/5", bus.hit_pulse, bus.busy, bus.score);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (bus.score !== '0 || bus.busy !== 1'b0 || bus.hit_pulse !== 1'b0 || bus.miss_pulse !== 1'b0) begin
      errors++; $display("FAIL abort_immediate: got score=%0d busy=%b hit=%b miss=%b want 0/0/0/0",
                         bus.score, bus.busy, bus.hit_pulse, bus.miss_pulse);
    end
    bus.buttons = '0; bus.mole_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 5; i++) begin
      drive('0, 3'd2, 1'b0, 1'b0);
      checks++;
      if (bus.hit_pulse !== 1'b0 || bus.miss_pulse !== 1'b0 || bus.busy !== 1'b0) begin
        errors++; $display("FAIL abort_residual[%0d]: got hit=%b miss=%b busy=%b want 0/0/0", i, bus.hit_pulse, bus.miss_pulse, bus.busy);
      end
    end
  endtask

  task automatic test_random();
    logic [NB-1:0] b;
    logic [SW-1:0] sel;
    logic          mv, clr;
    int            hold;
    do_reset();
    b = '0; sel = 3'd2; mv = 1'b1; hold = 0;
    for (int i = 0; i < 600; i++) begin
      if (hold == 0) begin
        hold = $urandom_range(1, 4);
        case ($urandom_range(0, 3))
          0, 1:    b = '0;
          2:       b = NB'(1) << $urandom_range(0, NB - 1);
          default: b = NB'($urandom);
        endcase
        if ($urandom_range(0, 3) == 0) sel = SW'($urandom_range(0, 7));
      end
      hold--;
      if ($urandom_range(0, 5) == 0) mv = ~mv;
      clr = ($urandom_range(0, 19) == 0);
      drive(b, sel, mv, clr);
      checks++;
      if (bus.hit_pulse !== m_hit || bus.miss_pulse !== m_miss ||
          int'(bus.score) != m_score || bus.busy !== (m_mode == M_LOCKOUT) ||
          (bus.hit_pulse && bus.miss_pulse)) begin
        errors++;
        $display("FAIL random[%0d]: got hit=%b miss=%b score=%0d busy=%b want %b/%b/%0d/%b",
                 i, bus.hit_pulse, bus.miss_pulse, bus.score, bus.busy,
                 m_hit, m_miss, m_score, (m_mode == M_LOCKOUT));
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_hit_latency();
    test_miss();
    test_lockout();
    test_saturation();
    test_bad_selector();
    test_reset_abort();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
